// File: rtl/clause_bank_scan.sv
// ============================================================================
// clause_bank_scan : clause-array scanner with unit propagation to a fixpoint
// Optional per-clause activity counters via `define CLAUSE_ACTIVITY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module clause_bank_scan #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CIDX  = 3,
  parameter int WIDTH_VIDX  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VARS*3-1:0]    var_value_i,
  output logic [NUM_VARS*3-1:0]    var_value_o,
  input  logic [NUM_CLAUSES-1:0]   wr_i,
  input  logic [NUM_CLAUSES-1:0]   rd_i,
  input  logic [NUM_VARS*2-1:0]    clause_i,
  input  logic [WIDTH_C_LEN-1:0]   clause_len_i,
  output logic [NUM_VARS*2-1:0]    clause_o,
  output logic [WIDTH_C_LEN-1:0]   clause_len_o,
  input  logic                     start_i,
  input  logic                     apply_bkt_i,
  output logic                     busy_o,
  output logic                     imp_valid_o,
  input  logic                     imp_ready_i,
  output logic [WIDTH_VIDX-1:0]    imp_var_o,
  output logic [1:0]               imp_val_o,
  output logic [WIDTH_CIDX-1:0]    imp_cidx_o,
  output logic                     conflict_o,
  output logic [WIDTH_CIDX-1:0]    conflict_cidx_o,
  output logic                     done_o,
  output logic                     all_c_sat_o
`ifdef CLAUSE_ACTIVITY_EN
  ,
  output logic [7:0]               activity_o
`endif
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_SCAN     = 3'd1;
  localparam logic [2:0] c_IMPLY    = 3'd2;
  localparam logic [2:0] c_CONFLICT = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;
  localparam logic [WIDTH_CIDX-1:0] c_LAST = WIDTH_CIDX'(NUM_CLAUSES - 1);

  logic [NUM_VARS*2-1:0]  r_lits   [NUM_CLAUSES];
  logic [WIDTH_C_LEN-1:0] r_len    [NUM_CLAUSES];
  logic [WIDTH_VIDX-1:0]  r_rvar   [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] r_valid;
  logic [NUM_CLAUSES-1:0] r_reason;
  logic [NUM_VARS*3-1:0]  r_vals;
  logic [2:0]             r_state;
  logic [WIDTH_CIDX-1:0]  r_idx;
  logic                   r_pass_changed;
  logic                   r_all_sat;
  logic                   r_all_c_sat;
  logic                   r_conflict;
  logic [WIDTH_CIDX-1:0]  r_conf_cidx;
  logic [WIDTH_VIDX-1:0]  r_imp_var;
  logic [1:0]             r_imp_val;
`ifdef CLAUSE_ACTIVITY_EN
  logic [7:0]             r_act    [NUM_CLAUSES];
`endif

  logic                   w_sat;
  logic [1:0]             w_free_cnt;
  logic [WIDTH_VIDX-1:0]  w_free_var;
  logic [1:0]             w_free_lit;
  logic [1:0]             w_lit;
  logic [1:0]             w_val;
  logic                   w_last;
  logic [NUM_CLAUSES-1:0] w_bkt_free;

  // Evaluate the clause under the scan index; free count saturates at 2.
  always_comb begin
    w_sat      = 1'b0;
    w_free_cnt = 2'd0;
    w_free_var = '0;
    w_free_lit = 2'b00;
    w_lit      = 2'b00;
    w_val      = 2'b00;
    for (int v = 0; v < NUM_VARS; v++) begin
      w_lit = r_lits[r_idx][2*v +: 2];
      w_val = r_vals[3*v +: 2];
      if (w_lit == 2'b01 || w_lit == 2'b10) begin
        if (w_lit == w_val) begin
          w_sat = 1'b1;
        end else if (w_val == 2'b00) begin
          if (w_free_cnt != 2'd2) w_free_cnt = w_free_cnt + 2'd1;
          w_free_var = WIDTH_VIDX'(v);
          w_free_lit = w_lit;
        end
      end
    end
  end

  always_comb begin
    w_bkt_free = '0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      for (int v = 0; v < NUM_VARS; v++) begin
        if (WIDTH_VIDX'(v) == r_rvar[c] && var_value_i[3*v +: 2] == 2'b00)
          w_bkt_free[c] = 1'b1;
      end
    end
  end

  assign w_last = (r_idx == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_IDLE;
      r_idx          <= '0;
      r_pass_changed <= 1'b0;
      r_all_sat      <= 1'b0;
      r_all_c_sat    <= 1'b0;
      r_conflict     <= 1'b0;
      r_conf_cidx    <= '0;
      r_imp_var      <= '0;
      r_imp_val      <= 2'b00;
      r_vals         <= '0;
      r_valid        <= '0;
      r_reason       <= '0;
      for (int c = 0; c < NUM_CLAUSES; c++) begin
        r_lits[c] <= '0;
        r_len[c]  <= '0;
        r_rvar[c] <= '0;
`ifdef CLAUSE_ACTIVITY_EN
        r_act[c]  <= 8'd0;
`endif
      end
    end else begin
      case (r_state)
        c_IDLE: begin
          if (apply_bkt_i) begin
            r_vals     <= var_value_i;
            r_conflict <= 1'b0;
            for (int c = 0; c < NUM_CLAUSES; c++)
              if (r_reason[c] && w_bkt_free[c]) r_reason[c] <= 1'b0;
          end else if (start_i) begin
            r_vals         <= var_value_i;
            r_idx          <= '0;
            r_pass_changed <= 1'b0;
            r_all_sat      <= 1'b1;
            r_all_c_sat    <= 1'b0;
            r_conflict     <= 1'b0;
            r_state        <= c_SCAN;
          end
          // A write lands after the backtrack release so it always wins.
          for (int c = 0; c < NUM_CLAUSES; c++) begin
            if (wr_i[c]) begin
              r_lits[c]   <= clause_i;
              r_len[c]    <= clause_len_i;
              r_valid[c]  <= (clause_len_i != '0);
              r_reason[c] <= 1'b0;
`ifdef CLAUSE_ACTIVITY_EN
              r_act[c]    <= 8'd0;
`endif
            end
          end
        end
        c_SCAN: begin
          if (r_valid[r_idx] && !w_sat && w_free_cnt == 2'd0) begin
            r_state     <= c_CONFLICT;
            r_conflict  <= 1'b1;
            r_conf_cidx <= r_idx;
            r_all_sat   <= 1'b0;
`ifdef CLAUSE_ACTIVITY_EN
            if (r_act[r_idx] != 8'hFF) r_act[r_idx] <= r_act[r_idx] + 8'd1;
`endif
          end else if (r_valid[r_idx] && !w_sat && w_free_cnt == 2'd1) begin
            r_state   <= c_IMPLY;
            r_imp_var <= w_free_var;
            r_imp_val <= w_free_lit;
          end else begin
            if (r_valid[r_idx] && !w_sat) r_all_sat <= 1'b0;
            if (!w_last) begin
              r_idx <= r_idx + WIDTH_CIDX'(1);
            end else if (r_pass_changed) begin
              r_idx          <= '0;
              r_pass_changed <= 1'b0;
              r_all_sat      <= 1'b1;
            end else begin
              r_state <= c_DONE;
            end
          end
        end
        c_IMPLY: begin
          if (imp_ready_i) begin
            for (int v = 0; v < NUM_VARS; v++)
              if (WIDTH_VIDX'(v) == r_imp_var) r_vals[3*v +: 3] <= {1'b1, r_imp_val};
            r_reason[r_idx] <= 1'b1;
            r_rvar[r_idx]   <= r_imp_var;
`ifdef CLAUSE_ACTIVITY_EN
            if (r_act[r_idx] != 8'hFF) r_act[r_idx] <= r_act[r_idx] + 8'd1;
`endif
            r_state <= c_SCAN;
            if (!w_last) begin
              r_idx          <= r_idx + WIDTH_CIDX'(1);
              r_pass_changed <= 1'b1;
            end else begin
              r_idx          <= '0;
              r_pass_changed <= 1'b0;
              r_all_sat      <= 1'b1;
            end
          end
        end
        c_CONFLICT: r_state <= c_DONE;
        c_DONE: begin
          r_all_c_sat <= r_all_sat;
          r_state     <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    clause_o     = '0;
    clause_len_o = '0;
`ifdef CLAUSE_ACTIVITY_EN
    activity_o   = 8'd0;
`endif
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      if (rd_i[c]) begin
        clause_o = clause_o | r_lits[c];
        if (!r_reason[c]) clause_len_o = clause_len_o | r_len[c];
`ifdef CLAUSE_ACTIVITY_EN
        activity_o = activity_o | r_act[c];
`endif
      end
    end
  end

  assign var_value_o     = r_vals;
  assign busy_o          = (r_state != c_IDLE);
  assign imp_valid_o     = (r_state == c_IMPLY);
  assign imp_var_o       = r_imp_var;
  assign imp_val_o       = r_imp_val;
  assign imp_cidx_o      = r_idx;
  assign conflict_o      = r_conflict;
  assign conflict_cidx_o = r_conf_cidx;
  assign done_o          = (r_state == c_DONE);
  assign all_c_sat_o     = (r_state == c_DONE) ? r_all_sat : r_all_c_sat;

endmodule

`default_nettype wire
